// File: rtl/io_output_bank_if.sv
// Register-bus and per-channel handshake bundle for io_output_bank.
// The bank connects to the slave modport; the bus driver or bench connects to the master modport.
interface io_output_bank_if #(
    parameter int NUM_PORTS = 3,
    parameter int DATA_W    = 32
);
    logic [31:0]                  addr;
    logic [31:0]                  datain;
    logic                         write_io_enable;
    logic [NUM_PORTS-1:0]         upd_ack;
    logic [NUM_PORTS*DATA_W-1:0]  out_port;
    logic [NUM_PORTS-1:0]         sign_led;
    logic [NUM_PORTS-1:0]         upd_valid;
    logic [31:0]                  dataout;

    modport master (
        output addr, datain, write_io_enable, upd_ack,
        input  out_port, sign_led, upd_valid, dataout
    );

    modport slave (
        input  addr, datain, write_io_enable, upd_ack,
        output out_port, sign_led, upd_valid, dataout
    );
endinterface

// File: rtl/io_output_bank.sv
// Shadow/commit output register bank with per-channel valid/ack handshake and overrun flags.
// Define IO_OUTPUT_SIGNMAG_EN to build the CTRL register and the per-channel sign-magnitude output.
module io_output_chan #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              shadow_wr,
    input  logic              commit,
    input  logic              ack,
    input  logic              ovr_clr,
    input  logic              conv,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] shadow,
    output logic              dirty,
    output logic [DATA_W-1:0] out_val,
    output logic              sign,
    output logic              valid,
    output logic              overrun
);
    logic take;
    logic neg;

    assign take = commit & dirty;
    assign neg  = conv & shadow[DATA_W-1];

    always_ff @(posedge clk) begin
        if (!clrn) begin
            shadow  <= '0;
            dirty   <= 1'b0;
            out_val <= '0;
            sign    <= 1'b0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (shadow_wr) begin
                shadow <= wdata;
                dirty  <= 1'b1;
            end else if (take) begin
                dirty  <= 1'b0;
            end
            if (take) begin
                // Negating the most negative value wraps back onto itself.
                out_val <= neg ? -shadow : shadow;
                sign    <= neg;
            end
            if (take)
                valid <= 1'b1;
            else if (ack)
                valid <= 1'b0;
            if (take && valid && !ack)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end
endmodule

module io_output_bank #(
    parameter int         NUM_PORTS = 3,
    parameter int         DATA_W    = 32,
    parameter logic [7:0] BASE_ADDR = 8'h80
) (
    input  logic             io_clk,
    input  logic             clrn,
    io_output_bank_if.slave  bus
);
    logic [5:0]                         wofs;
    logic                               wr;
    logic                               hit_ctrl;
    logic                               hit_commit;
    logic                               hit_status;
    logic [NUM_PORTS-1:0]               ctrl;
    logic [NUM_PORTS-1:0]               ovr_clr;
    logic [NUM_PORTS-1:0][DATA_W-1:0]   shadow;
    logic [NUM_PORTS-1:0][DATA_W-1:0]   out_q;
    logic [NUM_PORTS-1:0]               dirty;
    logic [NUM_PORTS-1:0]               sign;
    logic [NUM_PORTS-1:0]               valid;
    logic [NUM_PORTS-1:0]               overrun;
    logic [31:0]                        rdata;
    logic [31:0]                        dataout_q;
    logic                               unused_addr;

    // Word offset from the base; addresses below the base wrap out of range.
    assign wofs        = bus.addr[7:2] - BASE_ADDR[7:2];
    assign wr          = bus.write_io_enable;
    assign hit_ctrl    = (wofs == 6'd8);
    assign hit_commit  = (wofs == 6'd9);
    assign hit_status  = (wofs == 6'd10);
    assign ovr_clr     = {NUM_PORTS{wr & hit_status}} & bus.datain[16 +: NUM_PORTS];
    assign unused_addr = ^{bus.addr[31:8], bus.addr[1:0]};

`ifdef IO_OUTPUT_SIGNMAG_EN
    always_ff @(posedge io_clk) begin
        if (!clrn)
            ctrl <= '0;
        else if (wr && hit_ctrl)
            ctrl <= bus.datain[NUM_PORTS-1:0];
    end
`else
    assign ctrl = '0;
`endif

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_chan
        io_output_chan #(.DATA_W(DATA_W)) u_chan (
            .clk       (io_clk),
            .clrn      (clrn),
            .shadow_wr (wr && (wofs == 6'(i))),
            .commit    (wr && hit_commit),
            .ack       (bus.upd_ack[i]),
            .ovr_clr   (ovr_clr[i]),
            .conv      (ctrl[i]),
            .wdata     (bus.datain[DATA_W-1:0]),
            .shadow    (shadow[i]),
            .dirty     (dirty[i]),
            .out_val   (out_q[i]),
            .sign      (sign[i]),
            .valid     (valid[i]),
            .overrun   (overrun[i])
        );
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (wofs == 6'(i))
                rdata = 32'(shadow[i]);
        if (hit_ctrl)
            rdata = 32'(ctrl);
        if (hit_status)
            rdata = {8'h00, 8'(overrun), 8'(valid), 8'(dirty)};
    end

    always_ff @(posedge io_clk) begin
        if (!clrn)
            dataout_q <= '0;
        else
            dataout_q <= rdata;
    end

    assign bus.out_port  = out_q;
    assign bus.sign_led  = sign;
    assign bus.upd_valid = valid;
    assign bus.dataout   = dataout_q;
endmodule

// File: tb/tb_io_output_bank.sv
// Directed bench for io_output_bank: commit path, handshake/overrun, readback, reset.
// Sign-magnitude expectations follow whether IO_OUTPUT_SIGNMAG_EN is defined.
module tb_io_output_bank;
    localparam int NP = 3;
    localparam int DW = 32;

    logic io_clk = 1'b0;
    logic clrn   = 1'b0;
    int   checks = 0;
    int   passed = 0;

    io_output_bank_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();

    io_output_bank #(.NUM_PORTS(NP), .DATA_W(DW), .BASE_ADDR(8'h80)) dut (
        .io_clk (io_clk),
        .clrn   (clrn),
        .bus    (bus)
    );

    always #5 io_clk = ~io_clk;

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge io_clk);
        bus.addr = a; bus.datain = d; bus.write_io_enable = 1'b1;
        @(negedge io_clk);
        bus.write_io_enable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge io_clk);
        bus.addr = a; bus.write_io_enable = 1'b0;
        @(negedge io_clk);
        d = bus.dataout;
    endtask

    task automatic ack(input logic [NP-1:0] m);
        @(negedge io_clk);
        bus.upd_ack = m;
        @(negedge io_clk);
        bus.upd_ack = '0;
    endtask

    task automatic test_reset();
        bus.addr = 32'h80; bus.datain = 32'h0; bus.write_io_enable = 1'b0; bus.upd_ack = '0;
        clrn = 1'b0;
        repeat (2) @(negedge io_clk);
        checks++; if (bus.out_port !== '0) $display("FAIL reset_out: got %h want 0", bus.out_port); else passed++;
        checks++; if (bus.upd_valid !== '0) $display("FAIL reset_valid: got %b want 0", bus.upd_valid); else passed++;
        checks++; if (bus.sign_led !== '0) $display("FAIL reset_sign: got %b want 0", bus.sign_led); else passed++;
        checks++; if (bus.dataout !== 32'h0) $display("FAIL reset_dataout: got %h want 0", bus.dataout); else passed++;
        clrn = 1'b1;
    endtask

    task automatic test_commit();
        logic [31:0] d;
        wr(32'h80, 32'h0000_0005);
        checks++; if (bus.out_port[31:0] !== 32'h0) $display("FAIL pre_commit_out0: got %h want 0", bus.out_port[31:0]); else passed++;
        rd(32'hA8, d);
        checks++; if (d !== 32'h0000_0001) $display("FAIL pre_commit_status: got %h want 00000001", d); else passed++;
        wr(32'hA4, 32'hFFFF_FFFF);
        checks++; if (bus.out_port[31:0] !== 32'h5) $display("FAIL commit_out0: got %h want 5", bus.out_port[31:0]); else passed++;
        checks++; if (bus.upd_valid !== 3'b001) $display("FAIL commit_valid: got %b want 001", bus.upd_valid); else passed++;
        rd(32'hA8, d);
        checks++; if (d !== 32'h0000_0100) $display("FAIL commit_status: got %h want 00000100", d); else passed++;
        ack(3'b001);
        checks++; if (bus.upd_valid !== 3'b000) $display("FAIL ack_clear: got %b want 000", bus.upd_valid); else passed++;
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        wr(32'h84, 32'h11);
        wr(32'hA4, 32'h0);
        wr(32'h84, 32'h22);
        wr(32'hA4, 32'h0);
        checks++; if (bus.out_port[63:32] !== 32'h22) $display("FAIL ovr_out1: got %h want 22", bus.out_port[63:32]); else passed++;
        checks++; if (bus.upd_valid[1] !== 1'b1) $display("FAIL ovr_valid1: got %b want 1", bus.upd_valid[1]); else passed++;
        rd(32'hA8, d);
        checks++; if (d !== 32'h0002_0200) $display("FAIL ovr_status: got %h want 00020200", d); else passed++;
        wr(32'hA8, 32'h0002_0000);
        rd(32'hA8, d);
        checks++; if (d !== 32'h0000_0200) $display("FAIL ovr_clear: got %h want 00000200", d); else passed++;
        ack(3'b010);
        checks++; if (bus.upd_valid !== 3'b000) $display("FAIL ovr_ack: got %b want 000", bus.upd_valid); else passed++;
    endtask

    task automatic test_ack_commit();
        logic [31:0] d;
        wr(32'h80, 32'h7);
        wr(32'hA4, 32'h0);
        wr(32'h80, 32'h9);
        @(negedge io_clk);
        bus.addr = 32'hA4; bus.write_io_enable = 1'b1; bus.upd_ack = 3'b001;
        @(negedge io_clk);
        bus.write_io_enable = 1'b0; bus.upd_ack = '0;
        checks++; if (bus.upd_valid[0] !== 1'b1) $display("FAIL ackc_valid: got %b want 1", bus.upd_valid[0]); else passed++;
        checks++; if (bus.out_port[31:0] !== 32'h9) $display("FAIL ackc_out0: got %h want 9", bus.out_port[31:0]); else passed++;
        rd(32'hA8, d);
        checks++; if (d !== 32'h0000_0100) $display("FAIL ackc_status: got %h want 00000100", d); else passed++;
        ack(3'b001);
        checks++; if (bus.upd_valid[0] !== 1'b0) $display("FAIL ackc_clear: got %b want 0", bus.upd_valid[0]); else passed++;
    endtask

    task automatic test_signmag();
        logic [31:0] d;
        wr(32'hA0, 32'h4);
        rd(32'hA0, d);
`ifdef IO_OUTPUT_SIGNMAG_EN
        checks++; if (d !== 32'h4) $display("FAIL ctrl_read: got %h want 4", d); else passed++;
        wr(32'h88, 32'hFFFF_FFFD);
        wr(32'hA4, 32'h0);
        checks++; if (bus.out_port[95:64] !== 32'h3) $display("FAIL smag_out2: got %h want 3", bus.out_port[95:64]); else passed++;
        checks++; if (bus.sign_led !== 3'b100) $display("FAIL smag_sign: got %b want 100", bus.sign_led); else passed++;
        wr(32'h88, 32'h8000_0000);
        wr(32'hA4, 32'h0);
        checks++; if (bus.out_port[95:64] !== 32'h8000_0000) $display("FAIL smag_min: got %h want 80000000", bus.out_port[95:64]); else passed++;
        checks++; if (bus.sign_led !== 3'b100) $display("FAIL smag_min_sign: got %b want 100", bus.sign_led); else passed++;
`else
        checks++; if (d !== 32'h0) $display("FAIL ctrl_read: got %h want 0", d); else passed++;
        wr(32'h88, 32'hFFFF_FFFD);
        wr(32'hA4, 32'h0);
        checks++; if (bus.out_port[95:64] !== 32'hFFFF_FFFD) $display("FAIL pass_out2: got %h want fffffffd", bus.out_port[95:64]); else passed++;
        checks++; if (bus.sign_led !== 3'b000) $display("FAIL pass_sign: got %b want 000", bus.sign_led); else passed++;
`endif
        ack(3'b100);
    endtask

    task automatic test_decode();
        logic [31:0] d;
        @(negedge io_clk);
        bus.addr = 32'h84; bus.datain = 32'hDEAD; bus.write_io_enable = 1'b0;
        @(negedge io_clk);
        rd(32'h84, d);
        checks++; if (d !== 32'h22) $display("FAIL we_low_ignored: got %h want 22", d); else passed++;
        wr(32'hB0, 32'h1234);
        rd(32'hB0, d);
        checks++; if (d !== 32'h0) $display("FAIL unmapped_read: got %h want 0", d); else passed++;
        rd(32'hA8, d);
        checks++; if (d[7:0] !== 8'h00) $display("FAIL unmapped_no_dirty: got %h want 00", d[7:0]); else passed++;
    endtask

    task automatic test_reset_midflight();
        logic [31:0] d;
        wr(32'h84, 32'h1234);
        wr(32'hA4, 32'h0);
        wr(32'h84, 32'h5678);
        @(negedge io_clk);
        clrn = 1'b0; bus.addr = 32'hA4; bus.write_io_enable = 1'b1; bus.upd_ack = 3'b010;
        @(negedge io_clk);
        checks++; if (bus.out_port !== '0) $display("FAIL rst_mid_out: got %h want 0", bus.out_port); else passed++;
        checks++; if (bus.upd_valid !== '0) $display("FAIL rst_mid_valid: got %b want 0", bus.upd_valid); else passed++;
        checks++; if (bus.dataout !== 32'h0) $display("FAIL rst_mid_dataout: got %h want 0", bus.dataout); else passed++;
        clrn = 1'b1; bus.write_io_enable = 1'b0; bus.upd_ack = '0;
        rd(32'hA8, d);
        checks++; if (d !== 32'h0) $display("FAIL rst_mid_status: got %h want 0", d); else passed++;
        wr(32'h84, 32'hCAFE);
        rd(32'h84, d);
        checks++; if (d !== 32'hCAFE) $display("FAIL readback_ch1: got %h want cafe", d); else passed++;
    endtask

    initial begin
        test_reset();
        test_commit();
        test_overrun();
        test_ack_commit();
        test_signmag();
        test_decode();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
